// File: rtl/mc_pkg.sv
// Shared constants and types for the MC3999 execute stage.
package mc_pkg;

  localparam int MC_MAX = 999;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_TEQ = 4'd6;
  localparam logic [3:0] OP_TGT = 4'd7;
  localparam logic [3:0] OP_TLT = 4'd8;
  localparam logic [3:0] OP_SLP = 4'd9;

  localparam int ACC = 0;
  localparam int DAT = 1;
  localparam int P0  = 2;
  localparam int P1  = 3;

  localparam logic [1:0] COND_NONE = 2'b00;
  localparam logic [1:0] COND_POS  = 2'b01;
  localparam logic [1:0] COND_NEG  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SLEEP = 2'd2
  } state_t;

endpackage

// File: rtl/mc_sat.sv
// Combinational clamp of a wide signed value to +/-MC_MAX, narrowed to OW bits.
module mc_sat
  import mc_pkg::*;
#(
  parameter int IW = 22,
  parameter int OW = 11
) (
  input  logic signed [IW-1:0] i_val,
  output logic signed [OW-1:0] o_val
);

  localparam logic signed [IW-1:0] W_HI = IW'(MC_MAX);
  localparam logic signed [IW-1:0] W_LO = -W_HI;

  always_comb begin
    if (i_val > W_HI)      o_val = W_HI[OW-1:0];
    else if (i_val < W_LO) o_val = W_LO[OW-1:0];
    else                   o_val = i_val[OW-1:0];
  end

endmodule

// File: rtl/mc_exec_unit.sv
// MC3999 execute stage: IDLE -> EXEC -> (SLEEP) -> IDLE, driving the register file ports.
// Define MC_MUL_EN to build the multiplier; otherwise MUL retires as a NOP.
module mc_exec_unit
  import mc_pkg::*;
#(
  parameter int DW = 11,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    opcode,
  input  logic          a_imm,
  input  logic          b_imm,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_val,
  input  logic [DW-1:0] b_val,
  input  logic [AW-1:0] dst_addr,
  output logic [AW-1:0] read_addr0,
  output logic [AW-1:0] read_addr1,
  input  logic [DW-1:0] dat_out0,
  input  logic [DW-1:0] dat_out1,
  output logic [DW-1:0] write_dat,
  output logic [AW-1:0] write_addr,
  output logic          write_en,
  output logic [1:0]    cond,
  output logic          done,
  output logic          sleeping
);

  localparam int WW = 2 * DW;
`ifdef MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  state_t              r_state;
  logic [3:0]          r_op;
  logic                r_a_imm, r_b_imm;
  logic [AW-1:0]       r_a_addr, r_b_addr, r_dst;
  logic signed [DW-1:0] r_a_val, r_b_val;
  logic [DW-1:0]       r_cnt;
  logic [1:0]          r_cond;

  logic signed [DW-1:0] w_a_imm_sat, w_b_imm_sat, w_a, w_b, w_alu_sat;
  logic signed [WW-1:0] w_acc_w, w_a_w, w_alu_w;
  logic w_exec, w_alu, w_mov_slp, w_test, w_slp_go, w_test_true;

  mc_sat #(.IW(DW), .OW(DW)) u_sat_a   (.i_val($signed(a_val)), .o_val(w_a_imm_sat));
  mc_sat #(.IW(DW), .OW(DW)) u_sat_b   (.i_val($signed(b_val)), .o_val(w_b_imm_sat));
  mc_sat #(.IW(WW), .OW(DW)) u_sat_alu (.i_val(w_alu_w),        .o_val(w_alu_sat));

  assign w_exec    = (r_state == S_EXEC);
  assign w_alu     = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_NOT) ||
                     (MUL_ON && (r_op == OP_MUL));
  assign w_mov_slp = (r_op == OP_MOV) || (r_op == OP_SLP);
  assign w_test    = (r_op == OP_TEQ) || (r_op == OP_TGT) || (r_op == OP_TLT);

  // ALU ops take A on port 1 because port 0 is always the accumulator.
  assign w_a = r_a_imm ? r_a_val : (w_alu ? $signed(dat_out1) : $signed(dat_out0));
  assign w_b = r_b_imm ? r_b_val : $signed(dat_out1);

  assign w_acc_w  = WW'($signed(dat_out0));
  assign w_a_w    = WW'(w_a);
  assign w_slp_go = (r_op == OP_SLP) && (w_a > 0);

  always_comb begin
    read_addr0 = '0;
    read_addr1 = '0;
    if (w_exec) begin
      if (w_alu) begin
        read_addr0 = AW'(ACC);
        if (!r_a_imm) read_addr1 = r_a_addr;
      end else if (w_mov_slp || w_test) begin
        if (!r_a_imm) read_addr0 = r_a_addr;
        if (w_test && !r_b_imm) read_addr1 = r_b_addr;
      end
    end
  end

  always_comb begin
    w_alu_w = '0;
    case (r_op)
      OP_ADD:  w_alu_w = w_acc_w + w_a_w;
      OP_SUB:  w_alu_w = w_acc_w - w_a_w;
`ifdef MC_MUL_EN
      OP_MUL:  w_alu_w = w_acc_w * w_a_w;
`endif
      default: w_alu_w = '0;
    endcase
  end

  always_comb begin
    w_test_true = 1'b0;
    case (r_op)
      OP_TEQ:  w_test_true = (w_a == w_b);
      OP_TGT:  w_test_true = (w_a > w_b);
      OP_TLT:  w_test_true = (w_a < w_b);
      default: w_test_true = 1'b0;
    endcase
  end

  always_comb begin
    write_en   = 1'b0;
    write_addr = '0;
    write_dat  = '0;
    if (w_exec) begin
      if (r_op == OP_MOV) begin
        write_en   = 1'b1;
        write_addr = r_dst;
        write_dat  = w_a;
      end else if (r_op == OP_NOT) begin
        write_en   = 1'b1;
        write_addr = AW'(ACC);
        write_dat  = (dat_out0 == '0) ? DW'(100) : '0;
      end else if (w_alu) begin
        write_en   = 1'b1;
        write_addr = AW'(ACC);
        write_dat  = w_alu_sat;
      end
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign sleeping    = (r_state == S_SLEEP);
  assign done        = (w_exec && !w_slp_go) || (sleeping && (r_cnt == DW'(1)));
  assign cond        = r_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_a_imm  <= 1'b0;
      r_b_imm  <= 1'b0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_dst    <= '0;
      r_a_val  <= '0;
      r_b_val  <= '0;
      r_cnt    <= '0;
      r_cond   <= COND_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op     <= opcode;
            r_a_imm  <= a_imm;
            r_b_imm  <= b_imm;
            r_a_addr <= a_addr;
            r_b_addr <= b_addr;
            r_dst    <= dst_addr;
            r_a_val  <= w_a_imm_sat;
            r_b_val  <= w_b_imm_sat;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_test) r_cond <= w_test_true ? COND_POS : COND_NEG;
          if (w_slp_go) begin
            r_cnt   <= w_a;
            r_state <= S_SLEEP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SLEEP: begin
          if (r_cnt == DW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_exec_unit.sv
// Self-checking bench for mc_exec_unit with a register-file fixture and an arithmetic reference model.
module tb_mc_exec_unit;

  localparam int DW = 11;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    opcode = '0;
  logic          a_imm = 1'b0, b_imm = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, dst_addr = '0;
  logic [DW-1:0] a_val = '0, b_val = '0;
  logic [AW-1:0] read_addr0, read_addr1;
  logic [DW-1:0] dat_out0, dat_out1;
  logic [DW-1:0] write_dat;
  logic [AW-1:0] write_addr;
  logic          write_en;
  logic [1:0]    cond;
  logic          done, sleeping;

  mc_exec_unit #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .a_imm(a_imm), .b_imm(b_imm), .a_addr(a_addr), .b_addr(b_addr),
    .a_val(a_val), .b_val(b_val), .dst_addr(dst_addr),
    .read_addr0(read_addr0), .read_addr1(read_addr1),
    .dat_out0(dat_out0), .dat_out1(dat_out1),
    .write_dat(write_dat), .write_addr(write_addr), .write_en(write_en),
    .cond(cond), .done(done), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  // Register-file fixture: combinational reads, clocked write, cleared with the unit.
  logic [DW-1:0] rf [8];
  assign dat_out0 = rf[read_addr0];
  assign dat_out1 = rf[read_addr1];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (write_en) begin
      rf[write_addr] <= write_dat;
    end
  end

  int m_regs [8];
  int m_cond;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 999) return 999;
    if (x < -999) return -999;
    return x;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_cond = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    chk("rst_ready", instr_ready, 1);
    chk("rst_write_en", write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_sleeping", sleeping, 0);
    chk("rst_cond", cond, 0);
  endtask

  // Issue one instruction and check it to retirement; rst_at > 0 asserts reset in that SLEEP cycle.
  task automatic run_instr(input int op, input bit aimm, input int aaddr, input int aval,
                           input bit bimm, input int baddr, input int bval, input int dst,
                           input int rst_at);
    int a, b, acc, n, exp_we, exp_wa, exp_wd, er0, er1;
    logic [DW-1:0] tmp;
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    chk("idle_cond", cond, m_cond);
    chk("idle_ra0", read_addr0, 0);
    chk("idle_ra1", read_addr1, 0);
    for (int i = 0; i < 8; i++) begin
      tmp = rf[i];
      chk($sformatf("rf%0d", i), $signed(tmp), m_regs[i]);
    end
    opcode = op[3:0];
    a_imm = aimm; a_addr = aaddr[AW-1:0]; a_val = aval[DW-1:0];
    b_imm = bimm; b_addr = baddr[AW-1:0]; b_val = bval[DW-1:0];
    dst_addr = dst[AW-1:0];
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    opcode = 4'($urandom); a_val = DW'($urandom); b_val = DW'($urandom);
    a_addr = AW'($urandom); b_addr = AW'($urandom); dst_addr = AW'($urandom);
    a_imm = 1'($urandom); b_imm = 1'($urandom);

    a = aimm ? sat(aval) : m_regs[aaddr];
    b = bimm ? sat(bval) : m_regs[baddr];
    acc = m_regs[0];
    n = 0; exp_we = 0; exp_wa = 0; exp_wd = 0; er0 = 0; er1 = 0;
    case (op)
      1: begin exp_we = 1; exp_wa = dst; exp_wd = a; er0 = aimm ? 0 : aaddr; end
      2: begin exp_we = 1; exp_wd = sat(acc + a); er1 = aimm ? 0 : aaddr; end
      3: begin exp_we = 1; exp_wd = sat(acc - a); er1 = aimm ? 0 : aaddr; end
`ifdef MC_MUL_EN
      4: begin exp_we = 1; exp_wd = sat(acc * a); er1 = aimm ? 0 : aaddr; end
`endif
      5: begin exp_we = 1; exp_wd = (acc == 0) ? 100 : 0; er1 = aimm ? 0 : aaddr; end
      6: begin m_cond = (a == b) ? 1 : 2; er0 = aimm ? 0 : aaddr; er1 = bimm ? 0 : baddr; end
      7: begin m_cond = (a > b) ? 1 : 2;  er0 = aimm ? 0 : aaddr; er1 = bimm ? 0 : baddr; end
      8: begin m_cond = (a < b) ? 1 : 2;  er0 = aimm ? 0 : aaddr; er1 = bimm ? 0 : baddr; end
      9: begin n = a; er0 = aimm ? 0 : aaddr; end
      default: ;
    endcase

    chk($sformatf("op%0d_we", op), write_en, exp_we);
    if (exp_we != 0) begin
      chk($sformatf("op%0d_waddr", op), write_addr, exp_wa);
      chk($sformatf("op%0d_wdat", op), $signed(write_dat), exp_wd);
      m_regs[exp_wa] = exp_wd;
    end
    chk($sformatf("op%0d_done", op), done, (n > 0) ? 0 : 1);
    chk($sformatf("op%0d_ready", op), instr_ready, 0);
    chk($sformatf("op%0d_sleeping", op), sleeping, 0);
    chk($sformatf("op%0d_ra0", op), read_addr0, er0);
    chk($sformatf("op%0d_ra1", op), read_addr1, er1);

    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("slp_sleeping", sleeping, 1);
      chk("slp_ready", instr_ready, 0);
      chk("slp_we", write_en, 0);
      chk("slp_done", done, (k == n) ? 1 : 0);
      if (k == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        chk("slprst_ready", instr_ready, 1);
        chk("slprst_sleeping", sleeping, 0);
        chk("slprst_done", done, 0);
        chk("slprst_we", write_en, 0);
        chk("slprst_cond", cond, 0);
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    do_reset();

    run_instr(1, 1, 0,    42, 1, 0, 0, 3, 0);    // MOV 42 -> p1
    run_instr(1, 1, 0,   700, 1, 0, 0, 0, 0);    // acc = 700
    run_instr(2, 1, 0,   500, 1, 0, 0, 0, 0);    // ADD -> 999
    run_instr(3, 1, 0,  -999, 1, 0, 0, 0, 0);    // SUB -> 999
    run_instr(4, 1, 0,    -2, 1, 0, 0, 0, 0);    // MUL -> -999 when enabled
    run_instr(1, 1, 0,     5, 1, 0, 0, 0, 0);    // acc = 5
    run_instr(7, 0, 0,     0, 1, 0, 3, 0, 0);    // TGT acc, 3 -> +
    run_instr(6, 0, 0,     0, 1, 0, 4, 0, 0);    // TEQ acc, 4 -> -
    run_instr(0, 1, 0,     0, 1, 0, 0, 0, 0);    // NOP keeps cond
    run_instr(9, 1, 0,     3, 1, 0, 0, 0, 0);    // SLP 3
    run_instr(9, 1, 0,     3, 1, 0, 0, 0, 2);    // SLP 3, reset in 2nd cycle
    run_instr(9, 1, 0,     0, 1, 0, 0, 0, 0);    // SLP 0 retires in EXEC
    run_instr(9, 1, 0,    -5, 1, 0, 0, 0, 0);
    run_instr(1, 1, 0,    40, 1, 0, 0, 0, 0);
    run_instr(4, 1, 0,    30, 1, 0, 0, 0, 0);    // MUL 40*30
    run_instr(1, 1, 0,  1023, 1, 0, 0, 1, 0);    // immediate clamp high
    run_instr(1, 1, 0, -1024, 1, 0, 0, 2, 0);    // immediate clamp low
    run_instr(2, 0, 1,     0, 1, 0, 0, 0, 0);    // ADD register operand
    run_instr(5, 1, 0,     0, 1, 0, 0, 0, 0);    // NOT nonzero -> 0
    run_instr(5, 1, 0,     0, 1, 0, 0, 0, 0);    // NOT zero -> 100
    run_instr(8, 0, 2,     0, 0, 0, 0, 0, 0);    // TLT p0, acc
    run_instr(12, 1, 0,    7, 1, 0, 0, 0, 0);    // undefined opcode

    for (int it = 0; it < 150; it++) begin
      int op, aval, bval;
      bit aimm;
      op   = int'($urandom_range(0, 15));
      aimm = 1'($urandom);
      aval = int'($urandom_range(0, 2047)) - 1024;
      bval = int'($urandom_range(0, 2047)) - 1024;
      if (op == 9) begin
        aimm = 1'b1;
        aval = int'($urandom_range(0, 8)) - 3;
      end
      run_instr(op, aimm, int'($urandom_range(0, 7)), aval,
                1'($urandom), int'($urandom_range(0, 7)), bval,
                int'($urandom_range(0, 7)), 0);
    end

    @(negedge clk);
    chk("final_cond", cond, m_cond);
    chk("final_acc", $signed(dat_out0), m_regs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_exec_unit.md
# mc_exec_unit

Execute stage of the MC3999 microcontroller model: accepts one decoded instruction via a valid/ready handshake, reads operands from the MC3999 register file, performs the ALU/test/sleep operation with ±999 saturation, and writes the result back through the register file's write port. Sits directly upstream of the register file, driving its read addresses and write port and consuming its `dat_out0`/`dat_out1`.

## Interface
- `DW`, 11: data width (two's complement); legal value range is −999..+999.
- `AW`, 3: register address width.
- `clk`  in  1  clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  unit can accept.
- `opcode`  in  4  0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 MUL, 5 NOT, 6 TEQ, 7 TGT, 8 TLT, 9 SLP; 10–15 execute as NOP.
- `a_imm`, `b_imm`  in  1 each  operand is immediate (1) or register (0).
- `a_addr`, `b_addr`  in  AW each  operand register address.
- `a_val`, `b_val`  in  DW each  operand immediate value.
- `dst_addr`  in  AW  MOV destination.
- `read_addr0`, `read_addr1`  out  AW each  to register file.
- `dat_out0`, `dat_out1`  in  DW each  from register file, combinational on the read address.
- `write_dat`  out  DW, `write_addr`  out  AW, `write_en`  out  1  register file write port.
- `cond`  out  2  00 none, 01 "+", 10 "−".
- `done`  out  1  one-cycle pulse at instruction retirement.
- `sleeping`  out  1  SLP in progress.

## Operation
- Register map: 0 acc, 1 dat, 2 p0, 3 p1.
- States: IDLE → EXEC → (SLEEP) → IDLE. `instr_ready` = 1 only in IDLE.
- Accept on `instr_valid & instr_ready`; latch all instruction fields; go to EXEC.
- Immediates clamp to ±999 when latched.
- Reads in EXEC:
  - ADD/SUB/MUL/NOT: `read_addr0` = 0 (acc), `read_addr1` = `a_addr`.
  - MOV/SLP: `read_addr0` = `a_addr`.
  - TEQ/TGT/TLT: `read_addr0` = `a_addr`, `read_addr1` = `b_addr`.
  - Any port unused by the instruction, or whose operand is immediate, drives 0. Outside EXEC both ports drive 0, because a read of p0/p1 clears that pin.
- Results:
  - MOV: write A to `dst_addr`.
  - ADD/SUB/MUL: acc ± A or acc × A, computed at full width, saturated to ±999, written to addr 0.
  - NOT: acc = (acc == 0) ? 100 : 0.
  - TEQ/TGT/TLT: compare A with B. True → `cond` = 01, false → 10. No write.
  - NOP: no write, `cond` unchanged.
- SLP: N = A. N ≤ 0 retires in EXEC. Otherwise enter SLEEP, with `sleeping` = 1 for exactly N cycles.

## Timing
- Reset values: `instr_ready` 1; all other outputs 0; state IDLE; `cond` 00.
- Cycle T: handshake. T+1: EXEC — `write_en` high for this cycle only (where applicable), with `write_dat`/`write_addr` valid; `done` = 1 unless SLP with N ≥ 1. T+2: IDLE, ready = 1. Throughput: one instruction per 2 cycles.
- SLP N ≥ 1: SLEEP occupies T+2..T+1+N; `done` pulses on the last SLEEP cycle; IDLE at T+2+N.
- `instr_valid` while ready = 0 is ignored; the upstream stage holds it.
- `cond` updates at the end of the EXEC cycle and persists until the next test instruction or reset.
- Reset in any state, including mid-SLEEP: next cycle IDLE, sleep count cleared, no write, no `done`.

## Configuration
- `MC_MUL_EN` defined: MUL implemented as above.
- `MC_MUL_EN` undefined: no multiplier synthesized; MUL executes as NOP (no write, `done` still pulses).

## Structure
- Package `mc_pkg`: opcode constants, register address constants (ACC, DAT, P0, P1), `MC_MAX` = 999, `cond` encodings, FSM state type.
- Sub-module `mc_sat`: combinational clamp of a wide signed value to ±`MC_MAX`. Used for ALU results and immediate latching.

## Test plan
- Reset → `instr_ready` 1, `write_en`/`done`/`sleeping` 0, `cond` 00.
- MOV imm 42 → dst 3 → exactly one EXEC cycle with `write_en` 1, `write_addr` 3, `write_dat` 42; `done` pulse; ready 1 one cycle later.
- acc = 700, ADD imm 500 → acc 999. Then SUB imm −999 → acc 999. Then MUL imm −2 → acc −999.
- acc = 5: TGT acc, imm 3 → `cond` 01. TEQ acc, imm 4 → `cond` 10. Following NOP leaves `cond` 10.
- SLP imm 3 → `sleeping` high 3 cycles, ready low throughout, `done` on 3rd cycle. Repeat with reset in 2nd cycle → IDLE next cycle, no `done`.
- acc = 40, MUL imm 30 → 999 with `MC_MUL_EN` defined; no write and acc stays 40 without it.
